sys_controller: RTL and testbench



---
 rtl/sys_controller.sv | 104 ++++++++++
 tb/tb_sys_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sys_controller.sv
// rtl/sys_controller.sv - board clock/reset root: clock pass-through, reset synchroniser, lock model, reset stretch
// Power-up values come from declaration initialisers so the outputs are defined before any pad reset.
module sys_controller #(
  parameter int LOCK_CYCLES     = 16,
  parameter int RST_HOLD_CYCLES = 8
) (
  input  logic clk_pad,
  input  logic rst_pad,
  output logic clk_o,
  output logic rst_o,
  output logic locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_LOCKING = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e              state_q    = ST_RESET;
  state_e              state_d;
  logic                s1_q       = 1'b1;
  logic                s2_q       = 1'b1;
  logic                rst_o_q    = 1'b1;
  logic                rst_o_d;
  logic                locked_q   = 1'b0;
  logic                locked_d;
  logic [LOCK_W-1:0]   lock_cnt_q = '0;
  logic [LOCK_W-1:0]   lock_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q = '0;
  logic [HOLD_W-1:0]   hold_cnt_d;
  logic [LOCK_W-1:0]   lock_nxt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic                rst_int;

  assign clk_o   = clk_pad;
  assign rst_int = s2_q;
  assign rst_o   = rst_o_q;
  assign locked  = locked_q;

  assign lock_nxt = lock_cnt_q + 1'b1;
  assign hold_nxt = hold_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    locked_d   = locked_q;
    rst_o_d    = rst_o_q;
    if (rst_int) begin
      state_d    = ST_RESET;
      lock_cnt_d = '0;
      hold_cnt_d = '0;
      locked_d   = 1'b0;
      rst_o_d    = 1'b1;
    end else begin
      case (state_q)
        ST_RESET, ST_LOCKING: begin
          state_d = ST_LOCKING;
          if (lock_cnt_q < LOCK_MAX) begin
            lock_cnt_d = lock_nxt;
            if (lock_nxt == LOCK_MAX) begin
              locked_d = 1'b1;
              state_d  = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Counter saturates at HOLD_MAX; rst_o drops on the same edge it gets there.
          if (hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_nxt;
            if (hold_nxt == HOLD_MAX) begin
              rst_o_d = 1'b0;
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pad) begin
    s1_q       <= rst_pad;
    s2_q       <= s1_q;
    state_q    <= state_d;
    lock_cnt_q <= lock_cnt_d;
    hold_cnt_q <= hold_cnt_d;
    locked_q   <= locked_d;
    rst_o_q    <= rst_o_d;
  end

endmodule

// File: tb/tb_sys_controller.sv
// tb/tb_sys_controller.sv - directed bench for sys_controller reset/lock sequencing
module tb_sys_controller;

  logic clk_pad;
  logic rst_pad;
  logic clk_o;
  logic rst_o;
  logic locked;

  int checks = 0;
  int errors = 0;

  sys_controller #(
    .LOCK_CYCLES(16),
    .RST_HOLD_CYCLES(8)
  ) dut (
    .clk_pad(clk_pad),
    .rst_pad(rst_pad),
    .clk_o(clk_o),
    .rst_o(rst_o),
    .locked(locked)
  );

  initial begin
    clk_pad = 1'b0;
    forever #10 clk_pad = ~clk_pad;
  end

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_int(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_pad);
    #1;
  endtask

  // Next edge is E0+k_first; expected outputs follow from edge distance to E0.
  task automatic recover(input int k_first, input int k_last, input string tag);
    for (int k = k_first; k <= k_last; k++) begin
      step();
      check($sformatf("%s_locked_E%0d", tag, k), locked, logic'(k >= 17));
      check($sformatf("%s_rst_o_E%0d", tag, k), rst_o, logic'(k < 25));
    end
  endtask

  initial begin
    rst_pad = 1'b0;
    #1 rst_pad = 1'b1;
    #4;
    check("powerup_rst_o", rst_o, 1'b1);
    check("powerup_locked", locked, 1'b0);

    for (int i = 0; i < 100; i++) begin
      step();
      check("reset_hold_rst_o", rst_o, 1'b1);
      check("reset_hold_locked", locked, 1'b0);
    end

    // last edge was 1990 ns; release at 2001 ns so E0 = 2010 ns
    #10 rst_pad = 1'b0;
    check_int("release_time", longint'($time), 64'd2001);
    recover(0, 16, "boot");
    step();
    check_int("locked_rise_time", longint'($time), 64'd2351);
    check("boot_locked_E17", locked, 1'b1);
    check("boot_rst_o_E17", rst_o, 1'b1);
    recover(18, 24, "boot");
    step();
    check_int("rst_fall_time", longint'($time), 64'd2511);
    check("boot_locked_E25", locked, 1'b1);
    check("boot_rst_o_E25", rst_o, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      step();
      check("run_locked", locked, 1'b1);
      check("run_rst_o", rst_o, 1'b0);
      check("clk_o_high_early", clk_o, 1'b1);
      #8 check("clk_o_high_late", clk_o, 1'b1);
      #2 check("clk_o_low_early", clk_o, 1'b0);
      #8 check("clk_o_low_late", clk_o, 1'b0);
    end

    // one-cycle reset in RUN, sampled at edge A
    rst_pad = 1'b1;
    step();
    check("run_rst_A_locked", locked, 1'b1);
    check("run_rst_A_rst_o", rst_o, 1'b0);
    rst_pad = 1'b0;
    step();
    check("run_rst_A1_locked", locked, 1'b1);
    check("run_rst_A1_rst_o", rst_o, 1'b0);
    recover(1, 30, "runrst");

    // reset again, then a second pulse sampled at E10 of the lock phase
    rst_pad = 1'b1;
    step();
    rst_pad = 1'b0;
    step();
    check("lock_pre_A1_locked", locked, 1'b1);
    recover(1, 9, "lock1");
    rst_pad = 1'b1;
    step();
    check("lock_E10_locked", locked, 1'b0);
    check("lock_E10_rst_o", rst_o, 1'b1);
    rst_pad = 1'b0;
    recover(0, 20, "lock2");

    // pulse sampled at E21 of the hold phase
    rst_pad = 1'b1;
    step();
    check("hold_A_locked", locked, 1'b1);
    check("hold_A_rst_o", rst_o, 1'b1);
    rst_pad = 1'b0;
    step();
    check("hold_A1_locked", locked, 1'b1);
    check("hold_A1_rst_o", rst_o, 1'b1);
    recover(1, 30, "hold");

    // 5 ns glitch between edges must not be sampled
    #3 rst_pad = 1'b1;
    #5 rst_pad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("glitch_locked", locked, 1'b1);
      check("glitch_rst_o", rst_o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
